// File: rtl/twodigit_down_if.sv
// Trigger/preset/status bundle for the two-digit BCD countdown.
// master drives trigger, load and hold; slave returns digits and status.
interface twodigit_down_if;
  logic       t;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       hold;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       expired;
  logic       done;

  modport master (
    output t, load, load_tens, load_ones, hold,
    input  tens, ones, running, expired, done
  );

  modport slave (
    input  t, load, load_tens, load_ones, hold,
    output tens, ones, running, expired, done
  );
endinterface

// File: rtl/twodigit_down.sv
// Trigger-driven two-digit BCD countdown with preset load, hold and terminal pulse.
// Optional macro TWODIGIT_DOWN_AUTO_RELOAD_EN: an edge in EXPIRED reloads the stored preset.
module twodigit_down #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned START_TENS  = 9,
  parameter int unsigned START_ONES  = 9
) (
  input  logic         clk,
  input  logic         reset,
  twodigit_down_if.slave bus
);

  localparam int unsigned LP_STAGES     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [3:0]  LP_START_TENS = 4'(START_TENS);
  localparam logic [3:0]  LP_START_ONES = 4'(START_ONES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_COUNTING = 2'b01,
    ST_EXPIRED  = 2'b10
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LP_STAGES-1:0] r_sync;
  logic                 r_dly;
  logic                 w_edge;
  logic                 w_step;

  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic [3:0] r_pre_tens;
  logic [3:0] r_pre_ones;
  logic       r_done;
  logic [3:0] w_tens_nxt;
  logic [3:0] w_ones_nxt;
  logic [3:0] w_pre_tens_nxt;
  logic [3:0] w_pre_ones_nxt;
  logic       w_done_nxt;

  logic [3:0] w_ld_tens;
  logic [3:0] w_ld_ones;
  logic       w_ld_zero;

  // Trigger synchroniser plus one delay flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[LP_STAGES-2:0], bus.t};
      r_dly  <= r_sync[LP_STAGES-1];
    end
  end

  assign w_edge = r_sync[LP_STAGES-1] & ~r_dly;
  assign w_step = w_edge & ~bus.hold;

  assign w_ld_tens = (bus.load_tens > 4'd9) ? 4'd9 : bus.load_tens;
  assign w_ld_ones = (bus.load_ones > 4'd9) ? 4'd9 : bus.load_ones;
  assign w_ld_zero = (w_ld_tens == 4'd0) && (w_ld_ones == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tens     <= LP_START_TENS;
      r_ones     <= LP_START_ONES;
      r_pre_tens <= LP_START_TENS;
      r_pre_ones <= LP_START_ONES;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tens     <= w_tens_nxt;
      r_ones     <= w_ones_nxt;
      r_pre_tens <= w_pre_tens_nxt;
      r_pre_ones <= w_pre_ones_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Load wins over any edge in the same cycle; that edge is simply dropped
  always_comb begin
    w_state_nxt    = r_state;
    w_tens_nxt     = r_tens;
    w_ones_nxt     = r_ones;
    w_pre_tens_nxt = r_pre_tens;
    w_pre_ones_nxt = r_pre_ones;
    w_done_nxt     = 1'b0;

    if (bus.load) begin
      w_tens_nxt     = w_ld_tens;
      w_ones_nxt     = w_ld_ones;
      w_pre_tens_nxt = w_ld_tens;
      w_pre_ones_nxt = w_ld_ones;
      w_state_nxt    = w_ld_zero ? ST_EXPIRED : ST_COUNTING;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_COUNTING: begin
          if ((r_tens == 4'd0) && (r_ones == 4'd0)) begin
            w_state_nxt = ST_EXPIRED;
          end else if (w_step) begin
            if (r_ones != 4'd0) begin
              w_ones_nxt = r_ones - 4'd1;
            end else begin
              w_ones_nxt = 4'd9;
              w_tens_nxt = r_tens - 4'd1;
            end
            if ((r_tens == 4'd0) && (r_ones == 4'd1)) begin
              w_state_nxt = ST_EXPIRED;
              w_done_nxt  = 1'b1;
            end
          end
        end
        ST_EXPIRED: begin
`ifdef TWODIGIT_DOWN_AUTO_RELOAD_EN
          if (w_step && ((r_pre_tens != 4'd0) || (r_pre_ones != 4'd0))) begin
            w_tens_nxt  = r_pre_tens;
            w_ones_nxt  = r_pre_ones;
            w_state_nxt = ST_COUNTING;
          end
`else
          w_state_nxt = ST_EXPIRED;
`endif
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tens    = r_tens;
  assign bus.ones    = r_ones;
  assign bus.running = (r_state == ST_COUNTING);
  assign bus.expired = (r_state == ST_EXPIRED);
  assign bus.done    = r_done;

endmodule
